rx2in_ctl: RTL
==============

Name: rx2in_ctl

Overview:
Flow-control bridge from the UART receiver's one-cycle byte strobe into the CPU INBOX write port. The receiver emits bytes regardless of INBOX state, so bytes arriving while INBOX is full are held in a small local FIFO and drained into INBOX as space frees up. It is the mirror of out2txCtl, which drains OUTBOX into the transmitter. The FIFO overflow status is sticky and visible to the rest of the design.

Parameters:
DEPTH_LOG2, 3, log2 of local FIFO depth (DEPTH = 2^DEPTH_LOG2 = 8 entries)
RTS_THRESH, 6, fill level at or above which o_rts_n deasserts (used only with RX2IN_RTS_EN)

Ports:
clk  input  1  system clock, all state on posedge
i_rst  input  1  asynchronous, active-high reset
i_wr  input  1  one-cycle byte-valid strobe from UART RX
i_data  input  8  received byte, valid with i_wr
i_full  input  1  CPU INBOX full
i_clr_ovf  input  1  one-cycle pulse that clears o_overflow
o_wr  output  1  one-cycle write strobe to CPU INBOX
o_data  output  8  byte presented to INBOX, valid with o_wr
o_count  output  DEPTH_LOG2+1  current FIFO occupancy, 0..DEPTH
o_empty  output  1  FIFO empty (o_count == 0)
o_overflow  output  1  sticky: a byte was dropped
o_rts_n  output  1  active-low request-to-send (only with RX2IN_RTS_EN)

Behaviour:
- Reset (asynchronous, i_rst=1): o_wr=0, o_data=8'h00, o_count=0, o_empty=1, o_overflow=0, o_rts_n=0. Read/write pointers go to 0. FIFO contents are don't-care. A byte in flight is discarded.
- Storage: circular buffer with DEPTH_LOG2-bit rd/wr pointers that wrap modulo DEPTH. Occupancy is a separate (DEPTH_LOG2+1)-bit counter.
- Pop condition, evaluated on pre-edge values: pop = !o_empty && !i_full && !o_wr.
- On pop: o_wr<=1, o_data<=mem[rd_ptr], rd_ptr++. o_wr is otherwise 0.
- The !o_wr guard forces at least one idle cycle between INBOX writes, so i_full can update. Maximum drain rate is 1 byte per 2 cycles.
- o_data holds its last value when o_wr=0.
- Push condition: i_wr && (count < DEPTH || pop). On push: mem[wr_ptr]<=i_data, wr_ptr++.
- Push and pop on the same edge: count unchanged. A full FIFO with a simultaneous pop accepts the byte.
- Drop: i_wr while count == DEPTH and no pop. The byte is discarded, pointers and count are unchanged, and o_overflow<=1.
- o_overflow clears to 0 on i_clr_ovf. If i_clr_ovf and a drop occur on the same edge, the set wins (o_overflow=1).
- Latency: a byte pushed at edge N into an empty FIFO, with i_full=0 and o_wr=0, produces o_wr=1 and o_data=byte after edge N+1.
- Ordering is strict FIFO. No byte is ever duplicated. No byte is reordered.
- i_full rising while bytes are queued: popping stalls and nothing is lost until DEPTH bytes are queued.
- o_count and o_empty are registered and consistent with each other every cycle.

Optional Feature:
RX2IN_RTS_EN
- Defined: the o_rts_n port exists and is registered. o_rts_n<=1 when the post-edge count >= RTS_THRESH. o_rts_n<=0 when the post-edge count < RTS_THRESH-2, giving 2 entries of hysteresis. Otherwise o_rts_n holds its value.
- Not defined: the o_rts_n port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset, then push 8'h41 with i_full=0 -> o_wr pulses 1 cycle after the push edge with o_data=8'h41; o_count returns to 0; o_empty=1.
2. Hold i_full=1 and push 8'h10..8'h17 -> o_count=8, no o_wr. Release i_full -> 8 o_wr pulses spaced exactly 2 cycles apart, data 8'h10..8'h17 in order, o_overflow=0.
3. With the FIFO full and i_full=1, push 8'hAA -> byte dropped, o_count stays 8, o_overflow=1. Pulse i_clr_ovf -> o_overflow=0. Drained data contains no 8'hAA.
4. Same-edge cases:
   - FIFO full, i_full=0 and idle, push 8'h55 on the pop edge -> accepted, o_count stays 8, o_overflow stays 0, 8'h55 drains last.
   - Drop and i_clr_ovf on the same edge -> o_overflow=1.
5. Assert i_rst asynchronously mid-drain with 5 bytes queued -> o_wr=0, o_count=0, o_empty=1, o_overflow=0 immediately, without waiting for a clock edge. Subsequent push 8'h33 drains correctly.
6. With RX2IN_RTS_EN and RTS_THRESH=6, i_full=1:
   - Push 6 bytes -> o_rts_n=1 after the 6th push.
   - Release i_full -> o_rts_n stays 1 until count drops to 3, then goes 0.

Source files
------------

// File: rtl/rx2in_ctl.sv
`default_nettype none
// ============================================================================
// Module   : rx2in_ctl
// Purpose  : Flow-control bridge from the UART receiver byte strobe into the
//            CPU INBOX write port. Bytes that arrive while INBOX is full are
//            held in a small circular FIFO and drained as INBOX frees up.
//            A dropped byte (FIFO full, no pop) sets a sticky overflow flag.
// Options  : RX2IN_RTS_EN - adds the registered o_rts_n output, driven from
//            the post-edge occupancy with two entries of hysteresis.
// Revision : 1.0 - initial release
// ============================================================================
module rx2in_ctl #(
    parameter int DEPTH_LOG2 = 3,
    parameter int RTS_THRESH = 6
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_wr,
    input  logic [7:0]            i_data,
    input  logic                  i_full,
    input  logic                  i_clr_ovf,
    output logic                  o_wr,
    output logic [7:0]            o_data,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_empty,
    output logic                  o_overflow
`ifdef RX2IN_RTS_EN
    ,
    output logic                  o_rts_n
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                  c_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL_CNT = c_DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] c_CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE =
        {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------------
    logic [7:0]            r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;

    // ------------------------------------------------------------------------
    // Next-state helpers
    // ------------------------------------------------------------------------
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [DEPTH_LOG2:0]   w_count_nxt;
    logic                  w_ovf_nxt;

    // Pop/push/drop decisions from pre-edge state; the !o_wr term leaves an
    // idle cycle after every INBOX write so i_full can catch up.
    always_comb begin
        w_pop  = !o_empty && !i_full && !o_wr;
        w_push = i_wr && ((o_count != c_FULL_CNT) || w_pop);
        w_drop = i_wr && !w_push;

        w_count_nxt = o_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = o_count + c_CNT_ONE;
            2'b01:   w_count_nxt = o_count - c_CNT_ONE;
            default: w_count_nxt = o_count;
        endcase

        // A drop on the same edge as a clear request must leave the flag set.
        if (w_drop) begin
            w_ovf_nxt = 1'b1;
        end else if (i_clr_ovf) begin
            w_ovf_nxt = 1'b0;
        end else begin
            w_ovf_nxt = o_overflow;
        end
    end

    // FIFO array write; contents need no reset because pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Write pointer advances on every accepted byte and wraps modulo depth.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        end
    end

    // Read pointer and INBOX write port; o_data holds between strobes.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            o_wr     <= 1'b0;
            o_data   <= 8'h00;
        end else begin
            o_wr <= w_pop;
            if (w_pop) begin
                o_data   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Occupancy and empty flag are updated together so they never disagree.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_count <= '0;
            o_empty <= 1'b1;
        end else begin
            o_count <= w_count_nxt;
            o_empty <= (w_count_nxt == '0);
        end
    end

    // Sticky overflow flag.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_overflow <= 1'b0;
        end else begin
            o_overflow <= w_ovf_nxt;
        end
    end

`ifdef RX2IN_RTS_EN
    logic w_rts_set;
    logic w_rts_clr;

    // Hysteresis window: assert at the threshold, release two entries below.
    always_comb begin
        w_rts_set = int'(w_count_nxt) >= RTS_THRESH;
        w_rts_clr = int'(w_count_nxt) <  (RTS_THRESH - 2);
    end

    // Registered request-to-send, active low (1 = stop sending).
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_rts_n <= 1'b0;
        end else if (w_rts_set) begin
            o_rts_n <= 1'b1;
        end else if (w_rts_clr) begin
            o_rts_n <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire
